slot_payout_controller: RTL and testbench



---
 rtl/slot_payout_controller_pkg.sv | 32 +++
 rtl/slot_payout_controller_if.sv | 24 ++
 rtl/slot_payout_lut.sv | 43 ++++
 rtl/slot_payout_controller.sv | 153 +++++++++++++++
 tb/tb_slot_payout_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_payout_controller_pkg.sv
// Shared constants for the slot machine: icon codes, payout amounts, controller states.
package slot_pkg;

   localparam logic [2:0] WATERMELON = 3'd0;
   localparam logic [2:0] ORANGE     = 3'd1;
   localparam logic [2:0] APPLE      = 3'd2;
   localparam logic [2:0] CHERRY     = 3'd3;
   localparam logic [2:0] BAR        = 3'd4;
   localparam logic [2:0] BAR2       = 3'd5;
   localparam logic [2:0] BAR3       = 3'd6;
   localparam logic [2:0] JACKPOT    = 3'd7;

   localparam logic [7:0] PAY_JACKPOT    = 8'd100;
   localparam logic [7:0] PAY_BAR3       = 8'd50;
   localparam logic [7:0] PAY_BAR2       = 8'd25;
   localparam logic [7:0] PAY_BAR        = 8'd15;
   localparam logic [7:0] PAY_CHERRY     = 8'd10;
   localparam logic [7:0] PAY_APPLE      = 8'd8;
   localparam logic [7:0] PAY_ORANGE     = 8'd6;
   localparam logic [7:0] PAY_WATERMELON = 8'd4;
   localparam logic [7:0] PAY_ANY_BAR    = 8'd5;
   localparam logic [7:0] PAY_TWO_CHERRY = 8'd2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      LATCH  = 3'd2,
      EVAL   = 3'd3,
      PAY    = 3'd4
   } state_t;

endpackage

// File: rtl/slot_payout_controller_if.sv
// Spin interface between the reel spinner (master) and the payout controller (slave).
interface slot_payout_controller_if #(
   parameter int CREDIT_W = 10
);
   logic                spin;
   logic [2:0]          icon1;
   logic [2:0]          icon2;
   logic [2:0]          icon3;
   logic [CREDIT_W-1:0] credits;
   logic [7:0]          last_payout;
   logic                win;
   logic                busy;
   logic                reject;

   modport master (
      output spin, icon1, icon2, icon3,
      input  credits, last_payout, win, busy, reject
   );

   modport slave (
      input  spin, icon1, icon2, icon3,
      output credits, last_payout, win, busy, reject
   );
endinterface

// File: rtl/slot_payout_lut.sv
// Combinational payout table; the first matching row of the table wins.
module slot_payout_lut
   import slot_pkg::*;
(
   input  logic [2:0] icon1,
   input  logic [2:0] icon2,
   input  logic [2:0] icon3,
   output logic [7:0] payout
);

   logic       all_eq;
   logic       all_bar;
   logic [1:0] n_cherry;

   assign all_eq   = (icon1 == icon2) && (icon2 == icon3);
   assign all_bar  = (icon1 inside {BAR, BAR2, BAR3}) &&
                     (icon2 inside {BAR, BAR2, BAR3}) &&
                     (icon3 inside {BAR, BAR2, BAR3});
   assign n_cherry = 2'(icon1 == CHERRY) + 2'(icon2 == CHERRY) + 2'(icon3 == CHERRY);

   // Triples first, then mixed bars, then the two-cherry consolation.
   always_comb begin
      payout = 8'd0;
      if (all_eq) begin
         case (icon1)
            JACKPOT:    payout = PAY_JACKPOT;
            BAR3:       payout = PAY_BAR3;
            BAR2:       payout = PAY_BAR2;
            BAR:        payout = PAY_BAR;
            CHERRY:     payout = PAY_CHERRY;
            APPLE:      payout = PAY_APPLE;
            ORANGE:     payout = PAY_ORANGE;
            WATERMELON: payout = PAY_WATERMELON;
            default:    payout = 8'd0;
         endcase
      end else if (all_bar) begin
         payout = PAY_ANY_BAR;
      end else if (n_cherry == 2'd2) begin
         payout = PAY_TWO_CHERRY;
      end
   end

endmodule

// File: rtl/slot_payout_controller.sv
// Slot payout controller: synchronises the spin button, takes the bet on release,
// waits for the reels to settle, scores the icons and credits the winnings.
//
// state  | meaning
// IDLE   | waiting for a spin release; bet taken or release refused here
// SETTLE | settle down-counter running until terminal count 0
// LATCH  | capture the three reel icons
// EVAL   | register the payout from the table
// PAY    | add payout to balance (saturating), publish last_payout/win
module slot_payout_controller
   import slot_pkg::*;
#(
   parameter int START_CREDITS = 100,
   parameter int CREDIT_W      = 10,
   parameter int BET           = 1,
   parameter int MAX_CREDITS   = 999,
   parameter int SETTLE_CYC    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   slot_payout_controller_if.slave bus
);

   localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

   logic                sync1_q, sync2_q, prev_q;
   logic                rise;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CREDIT_W-1:0] credits_q, credits_d;
   logic [7:0]          last_payout_q, last_payout_d;
   logic                win_q, win_d;
   logic                reject_q, reject_d;
   logic [2:0]          ic1_q, ic2_q, ic3_q, ic1_d, ic2_d, ic3_d;
   logic [7:0]          payout_q, payout_d;
   logic [7:0]          lut_payout;
   logic [CREDIT_W:0]   sum;

   slot_payout_lut u_lut (
      .icon1  (ic1_q),
      .icon2  (ic2_q),
      .icon3  (ic3_q),
      .payout (lut_payout)
   );

   // Extra bit keeps the payout addition from wrapping before the ceiling compare.
   assign sum  = {1'b0, credits_q} + (CREDIT_W+1)'(payout_q);
   assign rise = sync2_q & ~prev_q;

   // Two-flop synchroniser on the raw button plus a delayed copy for release detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= bus.spin;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // State and datapath registers; a reset drops any pending payout without a refund.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         credits_q     <= CREDIT_W'(START_CREDITS);
         last_payout_q <= 8'd0;
         win_q         <= 1'b0;
         reject_q      <= 1'b0;
         ic1_q         <= 3'd0;
         ic2_q         <= 3'd0;
         ic3_q         <= 3'd0;
         payout_q      <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         credits_q     <= credits_d;
         last_payout_q <= last_payout_d;
         win_q         <= win_d;
         reject_q      <= reject_d;
         ic1_q         <= ic1_d;
         ic2_q         <= ic2_d;
         ic3_q         <= ic3_d;
         payout_q      <= payout_d;
      end
   end

   // Next-state and datapath updates; releases seen outside IDLE are dropped.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      credits_d     = credits_q;
      last_payout_d = last_payout_q;
      win_d         = win_q;
      reject_d      = 1'b0;
      ic1_d         = ic1_q;
      ic2_d         = ic2_q;
      ic3_d         = ic3_q;
      payout_d      = payout_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               if (credits_q >= CREDIT_W'(BET)) begin
                  credits_d     = credits_q - CREDIT_W'(BET);
                  last_payout_d = 8'd0;
                  win_d         = 1'b0;
                  cnt_d         = CNT_W'(SETTLE_CYC - 1);
                  state_d       = SETTLE;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = LATCH;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LATCH: begin
            ic1_d   = bus.icon1;
            ic2_d   = bus.icon2;
            ic3_d   = bus.icon3;
            state_d = EVAL;
         end
         EVAL: begin
            payout_d = lut_payout;
            state_d  = PAY;
         end
         PAY: begin
            if (sum > (CREDIT_W+1)'(MAX_CREDITS)) begin
               credits_d = CREDIT_W'(MAX_CREDITS);
            end else begin
               credits_d = sum[CREDIT_W-1:0];
            end
            last_payout_d = payout_q;
            win_d         = (payout_q != 8'd0);
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.credits     = credits_q;
   assign bus.last_payout = last_payout_q;
   assign bus.win         = win_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.reject      = reject_q;

endmodule

// File: tb/tb_slot_payout_controller.sv
// Bench for slot_payout_controller: two instances (normal start and near-ceiling
// start) share one stimulus stream and are checked every cycle against a
// transaction-level model, plus a few literal expectations at known cycles.
module tb_slot_payout_controller;

   localparam int S   = 4;
   localparam int BET = 1;
   localparam int MAX = 999;

   logic clock = 1'b0;
   logic reset;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   slot_payout_controller_if #(.CREDIT_W(10)) bus_a ();
   slot_payout_controller_if #(.CREDIT_W(10)) bus_b ();

   assign bus_b.spin  = bus_a.spin;
   assign bus_b.icon1 = bus_a.icon1;
   assign bus_b.icon2 = bus_a.icon2;
   assign bus_b.icon3 = bus_a.icon3;

   slot_payout_controller #(.START_CREDITS(100), .CREDIT_W(10), .BET(BET),
                            .MAX_CREDITS(MAX), .SETTLE_CYC(S)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   slot_payout_controller #(.START_CREDITS(998), .CREDIT_W(10), .BET(BET),
                            .MAX_CREDITS(MAX), .SETTLE_CYC(S)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   // ---------------- reference model ----------------
   int     start_c[2] = '{100, 998};
   int     cred[2];
   int     lastp[2];
   bit     winm[2];
   bit     rej[2];
   bit     act[2];
   longint n0[2];
   int     pay[2];
   bit     h0, h1, h2;
   longint cyc;

   function automatic int payout_model(input int a, input int b, input int c);
      int triple[8] = '{4, 6, 8, 10, 15, 25, 50, 100};
      int cherries;
      cherries = 0;
      if (a == 3) cherries++;
      if (b == 3) cherries++;
      if (c == 3) cherries++;
      if (a == b && b == c) return triple[a];
      if (a >= 4 && a <= 6 && b >= 4 && b <= 6 && c >= 4 && c <= 6) return 5;
      if (cherries == 2) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
         cred[i] = start_c[i]; lastp[i] = 0; winm[i] = 1'b0;
         rej[i] = 1'b0; act[i] = 1'b0; n0[i] = 0; pay[i] = 0;
      end
   endtask

   initial model_reset();

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_reset();
      end else begin
         bit r;
         cyc++;
         r = h1 & ~h2;   // button released two samples ago
         for (int i = 0; i < 2; i++) begin
            rej[i] = 1'b0;
            if (act[i]) begin
               if (cyc == n0[i] + S + 1)
                  pay[i] = payout_model(bus_a.icon1, bus_a.icon2, bus_a.icon3);
               if (cyc == n0[i] + S + 3) begin
                  cred[i]  = (cred[i] + pay[i] > MAX) ? MAX : cred[i] + pay[i];
                  lastp[i] = pay[i];
                  winm[i]  = (pay[i] != 0);
                  act[i]   = 1'b0;
               end
            end else if (r) begin
               if (cred[i] >= BET) begin
                  cred[i] = cred[i] - BET; lastp[i] = 0; winm[i] = 1'b0;
                  act[i] = 1'b1; n0[i] = cyc;
               end else begin
                  rej[i] = 1'b1;
               end
            end
         end
         h2 = h1; h1 = h0; h0 = bus_a.spin;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act_v, exp_v);
      end
   endtask

   task automatic cmp(input int i, input logic [9:0] c, input logic [7:0] lp,
                      input logic w, input logic b, input logic rj);
      check($sformatf("model_credits%0d", i), 32'(c), 32'(cred[i]));
      check($sformatf("model_last_payout%0d", i), 32'(lp), 32'(lastp[i]));
      check($sformatf("model_win%0d", i), 32'(w), 32'(winm[i]));
      check($sformatf("model_busy%0d", i), 32'(b), 32'(act[i]));
      check($sformatf("model_reject%0d", i), 32'(rj), 32'(rej[i]));
   endtask

   always @(posedge clock) begin
      #2;
      if (chk_en) begin
         cmp(0, bus_a.credits, bus_a.last_payout, bus_a.win, bus_a.busy, bus_a.reject);
         cmp(1, bus_b.credits, bus_b.last_payout, bus_b.win, bus_b.busy, bus_b.reject);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic release_spin(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      @(negedge clock) bus_a.spin = 1'b0;
      @(negedge clock);
      bus_a.spin  = 1'b1;
      bus_a.icon1 = a; bus_a.icon2 = b; bus_a.icon3 = c;
   endtask

   task automatic play(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      release_spin(a, b, c);
      repeat (14) @(negedge clock);
   endtask

   task automatic pulse_reset();
      @(negedge clock) reset = 1'b1;
      @(negedge clock) reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus_a.spin = 1'b1;
      bus_a.icon1 = 3'd0; bus_a.icon2 = 3'd0; bus_a.icon3 = 3'd0;
      repeat (2) @(negedge clock);
      chk_en = 1'b1;
      check("reset_credits_a", 32'(bus_a.credits), 32'd100);
      check("reset_credits_b", 32'(bus_b.credits), 32'd998);
      check("reset_last_payout", 32'(bus_a.last_payout), 32'd0);
      check("reset_busy", 32'(bus_a.busy), 32'd0);
      @(negedge clock) reset = 1'b0;
      repeat (3) @(negedge clock);

      // jackpot with exact timing: release before edge p, rise acted on at p+2, pay at p+9
      release_spin(3'd7, 3'd7, 3'd7);
      repeat (3) @(posedge clock);
      #2;
      check("jackpot_bet_a", 32'(bus_a.credits), 32'd99);
      check("jackpot_bet_b", 32'(bus_b.credits), 32'd997);
      repeat (6) @(posedge clock);
      #2;
      check("jackpot_early_a", 32'(bus_a.credits), 32'd99);
      check("jackpot_early_busy", 32'(bus_a.busy), 32'd1);
      @(posedge clock);
      #2;
      check("jackpot_credits_a", 32'(bus_a.credits), 32'd199);
      check("jackpot_credits_b_sat", 32'(bus_b.credits), 32'd999);
      check("jackpot_payout", 32'(bus_a.last_payout), 32'd100);
      check("jackpot_win", 32'(bus_a.win), 32'd1);
      check("jackpot_busy", 32'(bus_a.busy), 32'd0);
      repeat (4) @(negedge clock);

      play(3'd4, 3'd6, 3'd5);
      check("anybar_credits", 32'(bus_a.credits), 32'd203);
      check("anybar_payout", 32'(bus_a.last_payout), 32'd5);
      play(3'd3, 3'd1, 3'd3);
      check("twocherry_payout", 32'(bus_a.last_payout), 32'd2);
      play(3'd3, 3'd3, 3'd3);
      check("threecherry_payout", 32'(bus_a.last_payout), 32'd10);
      check("threecherry_credits", 32'(bus_a.credits), 32'd213);
      play(3'd0, 3'd1, 3'd2);
      check("lose_payout", 32'(bus_a.last_payout), 32'd0);
      check("lose_win", 32'(bus_a.win), 32'd0);
      check("lose_credits", 32'(bus_a.credits), 32'd212);

      // second release while busy must be ignored
      release_spin(3'd3, 3'd1, 3'd3);
      @(negedge clock);
      play(3'd3, 3'd1, 3'd3);
      check("busy_ignore_credits", 32'(bus_a.credits), 32'd213);
      check("busy_ignore_busy", 32'(bus_a.busy), 32'd0);

      // reset during SETTLE after the bet was taken
      release_spin(3'd7, 3'd7, 3'd7);
      repeat (4) @(negedge clock);
      check("midreset_deducted", 32'(bus_a.credits), 32'd212);
      check("midreset_busy", 32'(bus_a.busy), 32'd1);
      reset = 1'b1;
      #1;
      check("midreset_credits", 32'(bus_a.credits), 32'd100);
      check("midreset_busy_low", 32'(bus_a.busy), 32'd0);
      @(negedge clock) reset = 1'b0;
      repeat (14) @(negedge clock);
      check("midreset_no_payout", 32'(bus_a.last_payout), 32'd0);
      play(3'd3, 3'd3, 3'd3);
      check("after_reset_credits", 32'(bus_a.credits), 32'd109);
      check("after_reset_win", 32'(bus_a.win), 32'd1);

      // drain to zero, then a release must be refused
      pulse_reset();
      repeat (100) play(3'd0, 3'd1, 3'd2);
      check("drain_credits", 32'(bus_a.credits), 32'd0);
      release_spin(3'd7, 3'd7, 3'd7);
      repeat (3) @(posedge clock);
      #2;
      check("reject_pulse", 32'(bus_a.reject), 32'd1);
      check("reject_busy", 32'(bus_a.busy), 32'd0);
      check("reject_credits", 32'(bus_a.credits), 32'd0);
      @(posedge clock);
      #2;
      check("reject_one_cycle", 32'(bus_a.reject), 32'd0);
      repeat (14) @(negedge clock);

      // randomized releases, including ones landing while busy and occasional resets
      pulse_reset();
      for (int k = 0; k < 250; k++) begin
         logic [2:0] a, b, c;
         a = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            b = a; c = a;
         end else if ($urandom_range(0, 3) == 0) begin
            b = 3'($urandom_range(4, 6)); c = 3'($urandom_range(4, 6)); a = 3'($urandom_range(4, 6));
         end else begin
            b = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
         end
         @(negedge clock) bus_a.spin = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clock);
         @(negedge clock);
         bus_a.spin = 1'b1;
         bus_a.icon1 = a; bus_a.icon2 = b; bus_a.icon3 = c;
         repeat ($urandom_range(0, 12)) @(negedge clock);
         if ($urandom_range(0, 39) == 0) pulse_reset();
      end
      repeat (20) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
